// File: rtl/alu_instr_encoder_pkg.sv
// alu_instr_encoder_pkg: ALU control codes, RV32 opcode/funct constants and encoder types
package alu_instr_encoder_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_MIN = 4'd7,
        ALU_MAX = 4'd8
    } alu_op_e;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam logic [6:0] F7_MINMAX  = 7'b0000001;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SUB = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_MIN = 3'b000;
    localparam logic [2:0] F3_MAX = 3'b001;
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_e;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        last;
    } word_t;
endpackage

// File: rtl/alu_instr_encoder_pack.sv
// instr_pack: combinational R/I-type field packing with legality flag
module instr_pack
    import alu_instr_encoder_pkg::*;
(
    input  logic [3:0]  alucontrol,
    input  logic        is_imm,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] instr,
    output logic        legal
);
    logic [6:0] f7;
    logic [2:0] f3;
    logic       r_legal;
    logic       i_legal;
    always_comb begin
        f7 = F7_BASE;
        f3 = F3_ADD;
        r_legal = 1'b1;
        case (alu_op_e'(alucontrol))
            ALU_ADD: f3 = F3_ADD;
            ALU_SUB: begin f7 = F7_SUB; f3 = F3_SUB; end
            ALU_AND: f3 = F3_AND;
            ALU_OR:  f3 = F3_OR;
            ALU_XOR: f3 = F3_XOR;
            ALU_SLL: f3 = F3_SLL;
            ALU_SRL: f3 = F3_SRL;
            ALU_MIN: begin f7 = F7_MINMAX; f3 = F3_MIN; end
            ALU_MAX: begin f7 = F7_MINMAX; f3 = F3_MAX; end
            default: r_legal = 1'b0;
        endcase
    end
    assign i_legal = alucontrol inside {ALU_ADD, ALU_AND, ALU_OR};
    assign legal   = is_imm ? i_legal : r_legal;
    assign instr   = !legal ? '0 :
                     is_imm ? {imm, rs1, f3, rd, OPC_I} : {f7, rs2, rs1, f3, rd, OPC_R};
endmodule

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: streams ALU requests into RV32 words with imem addresses via a stage + 2-entry FIFO
module alu_instr_encoder
    import alu_instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_alucontrol,
    input  logic        in_is_imm,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [11:0] in_imm,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_last,
    output logic        err_illegal,
    output logic        busy,
    output logic        done,
    input  logic        clear
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam word_t RST_WORD = '{instr: '0, addr: BASE_ADDR, last: 1'b0};
    state_e        state, state_nx;
    word_t         stg;
    word_t         mem [2];
    logic          stg_valid, rd_ptr, wr_ptr, err_q, legal, accept, push, pop;
    logic [1:0]    count;
    logic [IW-1:0] idx;
    logic [31:0]   word;
    instr_pack u_pack (
        .alucontrol(in_alucontrol),
        .is_imm    (in_is_imm),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .imm       (in_imm),
        .instr     (word),
        .legal     (legal)
    );
    // stage and FIFO together never hold more than two words
    assign in_ready    = (state == S_IDLE || state == S_STREAM) && ((count + {1'b0, stg_valid}) < 2'd2);
    assign accept      = in_valid && in_ready;
    assign push        = stg_valid;
    assign pop         = out_valid && out_ready;
    assign out_valid   = count != 2'd0;
    assign out_instr   = mem[rd_ptr].instr;
    assign out_addr    = mem[rd_ptr].addr;
    assign out_last    = mem[rd_ptr].last;
    assign err_illegal = err_q;
    assign busy        = state == S_STREAM || state == S_DRAIN;
    assign done        = state == S_DONE;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = in_last ? S_DRAIN : S_STREAM;
            S_STREAM: if (accept && in_last) state_nx = S_DRAIN;
            S_DRAIN:  if (!stg_valid && count == 2'd0) state_nx = S_DONE;
            S_DONE:   if (clear) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            stg_valid <= 1'b0;
            stg       <= RST_WORD;
            mem[0]    <= RST_WORD;
            mem[1]    <= RST_WORD;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            idx       <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            stg_valid <= accept && legal;
            err_q     <= accept && !legal;
            if (accept && legal) begin
                stg <= '{instr: word, addr: BASE_ADDR + 32'({idx, 2'b00}), last: in_last};
                idx <= idx + IW'(1);
            end else if (state == S_DONE && clear) begin
                idx <= '0;
            end
            if (push) begin
                mem[wr_ptr] <= stg;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_alu_instr_encoder.sv
// tb_alu_instr_encoder: directed vectors checked against a queue-based encoder model every cycle
module tb_alu_instr_encoder;
    localparam logic [31:0] BASE = 32'h0;
    localparam int DEPTH = 4;
    logic clk = 0, reset = 1, in_valid = 0, in_is_imm = 0, in_last = 0, out_ready = 1, clear = 0;
    logic [3:0] in_alucontrol = 0;
    logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [11:0] in_imm = 0;
    logic in_ready, out_valid, out_last, err_illegal, busy, done;
    logic [31:0] out_instr, out_addr;
    always #5 clk = ~clk;
    alu_instr_encoder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_alucontrol(in_alucontrol), .in_is_imm(in_is_imm), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_last(out_last),
        .err_illegal(err_illegal), .busy(busy), .done(done), .clear(clear)
    );
    typedef struct {logic [31:0] instr; logic [31:0] addr; logic last; int t;} exp_t;
    typedef struct {logic [31:0] instr; logic [31:0] addr; logic last;} obs_t;
    logic [6:0] f7t [9] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h01, 7'h01};
    logic [2:0] f3t [9] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd0, 3'd1};
    exp_t q[$];
    obs_t seen[$];
    obs_t s_obs;
    logic [32:0] w;
    int total = 0, bad = 0, cyc = 0, n_m = 0;
    bit s_acc, s_pop, s_clear, err_m, closed, started, done_m, nd, ov;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", n, a, e, cyc);
        end
    endfunction

    // {legal, word} straight from the opcode/funct table
    function automatic logic [32:0] enc(logic [3:0] c, logic im, logic [4:0] rd, logic [4:0] rs1,
                                        logic [4:0] rs2, logic [11:0] imm);
        int k = int'(c);
        if (k > 8) return '0;
        if (im) return (k == 0 || k == 2 || k == 3) ? {1'b1, imm, rs1, f3t[k], rd, 7'b0010011} : 33'd0;
        return {1'b1, f7t[k], rs2, rs1, f3t[k], rd, 7'b0110011};
    endfunction

    always @(negedge clk) begin
        s_acc   = in_valid && in_ready;
        s_pop   = out_valid && out_ready;
        s_clear = clear;
        s_obs   = '{out_instr, out_addr, out_last};
        if (!reset) begin
            ov = q.size() > 0 && cyc >= q[0].t + 1;
            chk("in_ready", 32'(in_ready), 32'(!closed && q.size() < 2));
            chk("out_valid", 32'(out_valid), 32'(ov));
            if (ov) begin
                chk("out_instr", out_instr, q[0].instr);
                chk("out_addr", out_addr, q[0].addr);
                chk("out_last", 32'(out_last), 32'(q[0].last));
            end
            chk("err_illegal", 32'(err_illegal), 32'(err_m));
            chk("busy", 32'(busy), 32'(started && !done_m));
            chk("done", 32'(done), 32'(done_m));
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            {err_m, closed, started, done_m} = '0;
            n_m = 0;
        end else begin
            err_m = 0;
            nd = done_m || (closed && q.size() == 0);
            if (done_m && s_clear) begin
                nd = 0; closed = 0; started = 0; n_m = 0;
            end
            if (s_pop) begin
                seen.push_back(s_obs);
                if (q.size() > 0) void'(q.pop_front());
            end
            if (s_acc) begin
                w = enc(in_alucontrol, in_is_imm, in_rd, in_rs1, in_rs2, in_imm);
                started = 1;
                if (in_last) closed = 1;
                if (w[32]) begin
                    q.push_back('{w[31:0], BASE + 32'((n_m % DEPTH) * 4), in_last, cyc});
                    n_m++;
                end else err_m = 1;
            end
            done_m = nd;
        end
    end

    task automatic try_send(input logic [3:0] c, input logic im, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [11:0] imm, input logic last,
                            input int budget, output bit ok);
        {in_alucontrol, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, in_last} = {c, im, rd, rs1, rs2, imm, last};
        in_valid = 1;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send(input logic [3:0] c, input logic im, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm, input logic last);
        bit ok;
        try_send(c, im, rd, rs1, rs2, imm, last, 100, ok);
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout got=no_accept exp=accept code=%h", c);
        end
    endtask

    task automatic wait_done_clear(input string n);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL %s_done got=0 exp=1", n); end
        @(posedge clk); #1 clear = 1;
        @(posedge clk); #1 clear = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int acc;
        bit ok;
        logic [31:0] exp_addr [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_err", 32'(err_illegal), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        // single ADD x3,x1,x2: one cycle in the stage, then visible
        send(4'd0, 0, 5'd3, 5'd1, 5'd2, 12'd0, 1);
        @(negedge clk);
        chk("add_lat_stage", 32'(out_valid), 0);
        @(negedge clk);
        chk("add_lat_valid", 32'(out_valid), 1);
        chk("add_instr", out_instr, 32'h002081B3);
        chk("add_addr", out_addr, 32'h0);
        chk("add_busy", 32'(busy), 1);
        wait_done_clear("add");
        seen.delete();
        send(4'd1, 0, 5'd1, 5'd2, 5'd3, 12'd0, 0);
        send(4'd7, 0, 5'd5, 5'd6, 5'd7, 12'd0, 0);
        send(4'd8, 0, 5'd1, 5'd2, 5'd3, 12'd0, 1);
        wait_done_clear("prog3");
        chk("prog3_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("sub_instr", seen[0].instr, 32'h403100B3);
            chk("sub_addr", seen[0].addr, 32'h0);
            chk("min_instr", seen[1].instr, 32'h027302B3);
            chk("min_addr", seen[1].addr, 32'h4);
            chk("max_instr", seen[2].instr, 32'h023110B3);
            chk("max_addr", seen[2].addr, 32'h8);
            chk("max_last", 32'(seen[2].last), 1);
            chk("sub_last", 32'(seen[0].last), 0);
        end
        seen.delete();
        send(4'd2, 1, 5'd4, 5'd4, 5'd9, 12'h0FF, 0);
        send(4'd5, 1, 5'd1, 5'd1, 5'd0, 12'h001, 0);
        @(negedge clk);
        chk("slli_err_pulse", 32'(err_illegal), 1);
        @(negedge clk);
        chk("slli_err_clear", 32'(err_illegal), 0);
        @(posedge clk); #1;
        send(4'd3, 0, 5'd2, 5'd0, 5'd0, 12'd0, 1);
        wait_done_clear("imm");
        chk("imm_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("andi_instr", seen[0].instr, 32'h0FF27213);
            chk("andi_addr", seen[0].addr, 32'h0);
            chk("or_instr", seen[1].instr, 32'h00006133);
            chk("or_addr_reuse", seen[1].addr, 32'h4);
        end
        // full backpressure: only two requests fit, then order and wrap survive release
        seen.delete();
        out_ready = 0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            try_send(4'd0, 0, 5'(i + 1), 5'(i), 5'd0, 12'd0, i == 4, 4, ok);
            acc += int'(ok);
        end
        chk("bp_accepted", 32'(acc), 2);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1;
        for (int i = 2; i < 5; i++) send(4'd0, 0, 5'(i + 1), 5'(i), 5'd0, 12'd0, i == 4);
        wait_done_clear("bp");
        chk("bp_count", seen.size(), 5);
        if (seen.size() == 5)
            for (int k = 0; k < 5; k++) begin
                chk("bp_addr_wrap", seen[k].addr, exp_addr[k]);
                chk("bp_order_rd", 32'(seen[k].instr[11:7]), 32'(k + 1));
            end
        // reset with two words buffered
        seen.delete();
        out_ready = 0;
        send(4'd4, 0, 5'd1, 5'd2, 5'd3, 12'd0, 0);
        send(4'd6, 0, 5'd4, 5'd5, 5'd6, 12'd0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rst_flush_valid", 32'(out_valid), 0);
        chk("rst_flush_busy", 32'(busy), 0);
        chk("rst_flush_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        out_ready = 1;
        send(4'd0, 0, 5'd3, 5'd1, 5'd2, 12'd0, 1);
        wait_done_clear("rst");
        chk("rst_count", seen.size(), 1);
        if (seen.size() == 1) chk("rst_base_addr", seen[0].addr, BASE);
        // illegal last still closes the program; clear outside DONE is ignored
        seen.delete();
        send(4'd4, 0, 5'd7, 5'd8, 5'd9, 12'd0, 0);
        clear = 1;
        @(posedge clk); #1 clear = 0;
        send(4'd0, 1, 5'd31, 5'd31, 5'd0, 12'hFFF, 0);
        send(4'hA, 0, 5'd1, 5'd1, 5'd1, 12'd0, 1);
        wait_done_clear("illast");
        chk("illast_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("xor_instr", seen[0].instr, 32'h009443B3);
            chk("addi_max_instr", seen[1].instr, 32'hFFFF8F93);
            chk("addi_addr", seen[1].addr, 32'h4);
            chk("illast_no_last", 32'(seen[1].last), 0);
        end
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_instr_encoder.md
ALU_INSTR_ENCODER -- requirements
Module: alu_instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first emitted instruction.
REQ-002 Parameter DEPTH_WORDS, default 64: instruction-memory words before address wrap; power of two, at least 2.
REQ-003 Port clk, input, 1: single clock, all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: encode request present.
REQ-006 Port in_ready, output, 1: request accepted on an edge where in_valid && in_ready.
REQ-007 Ports in_alucontrol (4), in_is_imm (1), in_rd/in_rs1/in_rs2 (5 each), in_imm (12), in_last (1), all inputs: request fields.
REQ-008 Ports out_valid (output, 1) and out_ready (input, 1): output handshake; transfer when both are high.
REQ-009 Ports out_instr (32), out_addr (32), out_last (1), all outputs: encoded word, its imem byte address, end-of-program flag.
REQ-010 Port err_illegal, output, 1: one-cycle pulse for a dropped illegal request.
REQ-011 Ports busy (output, 1), done (output, 1), clear (input, 1): status and done acknowledge.

Function
REQ-012 Legal R-type encodings SHALL use opcode 0110011 with {funct7,funct3} as follows: 0000 ADD 0000000/000; 0001 SUB 0100000/000; 0010 AND 0000000/111; 0011 OR 0000000/110; 0100 XOR 0000000/100; 0101 SLL 0000000/001; 0110 SRL 0000000/101; 0111 MIN 0000001/000; 1000 MAX 0000001/001.
REQ-013 When in_is_imm=1, only ADD, AND and OR SHALL be legal; they encode as I-type, opcode 0010011, funct3 000/111/110, imm[11:0] in bits 31:20, and in_rs2 is ignored.
REQ-014 Codes 1001-1111, and an immediate request with any other code, SHALL be illegal: the request is accepted and dropped, err_illegal pulses on the following cycle, and no address is consumed.
REQ-015 Field placement SHALL be rd[11:7], rs1[19:15], rs2[24:20], funct3[14:12], funct7[31:25]; register x0 is legal in every field.
REQ-016 Each accepted legal request SHALL be encoded in one registered stage and then enter a 2-entry output FIFO.
REQ-017 Latency SHALL be 1 cycle: a request accepted at edge N with the FIFO empty gives out_valid=1 after edge N+1.
REQ-018 The output SHALL be FIFO head; out_instr/out_addr/out_last hold stable while out_valid && !out_ready.
REQ-019 in_ready SHALL equal (state is IDLE or STREAM) and (FIFO occupancy plus stage occupancy is less than 2), so nothing is lost under full backpressure.
REQ-020 Simultaneous FIFO push and pop when full SHALL be impossible by REQ-019; push and pop in the same cycle at occupancy 1 SHALL keep occupancy at 1.
REQ-021 The address counter SHALL start at BASE_ADDR, step +4 per legal instruction, and wrap to BASE_ADDR after DEPTH_WORDS instructions.
REQ-022 FSM states: IDLE, STREAM, DRAIN, DONE.
REQ-023 FSM transitions: IDLE to STREAM on the first accept; STREAM to DRAIN on accept with in_last=1; DRAIN to DONE when stage and FIFO are empty; DONE to IDLE on clear=1.
REQ-024 An illegal request carrying in_last=1 SHALL still move the FSM to DRAIN; out_last is then never asserted for that program.
REQ-025 out_last SHALL be 1 only on the word from a legal request carrying in_last=1.
REQ-026 On return to IDLE the address counter SHALL reload BASE_ADDR.
REQ-027 busy SHALL be 1 in STREAM and DRAIN; done SHALL be 1 only in DONE; clear SHALL be ignored in every state other than DONE.

Reset
REQ-028 Reset SHALL apply: state IDLE, FIFO and stage empty, address counter BASE_ADDR.
REQ-029 Reset SHALL apply: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_last=0, err_illegal=0, busy=0, done=0, in_ready=1 on the cycle after reset deasserts.
REQ-030 Reset mid-stream SHALL discard all buffered words with no partial output; reset has priority over every other input.

Structure
REQ-031 ALU control code enum, opcode constants (0110011, 0010011) and funct7/funct3 constants SHALL live in a shared package also used by the ALU decoder.
REQ-032 Combinational field packing SHALL be a sub-module named instr_pack (inputs: request fields; outputs: 32-bit word and a legal flag).

Verification
REQ-033 ADD x3,x1,x2 at BASE_ADDR=0 with out_ready=1 -> out_instr=0x002081B3, out_addr=0x0, one cycle after accept.
REQ-034 SUB x1,x2,x3 then MIN x5,x6,x7 then MAX x1,x2,x3 (last) -> 0x403100B3 @0x0, 0x027302B3 @0x4, 0x023110B3 @0x8 with out_last=1; done asserts after the drain.
REQ-035 ANDI x4,x4,0xFF -> 0x0FF27213; SLL with in_is_imm=1 -> err_illegal pulse and no output, and the next legal request reuses the address.
REQ-036 out_ready=0 with 5 requests offered -> exactly 2 accepted, then in_ready=0; release out_ready -> order and addresses preserved.
REQ-037 DEPTH_WORDS=4 with 5 legal requests -> addresses 0x0, 0x4, 0x8, 0xC, 0x0.
REQ-038 reset asserted with 2 words buffered -> out_valid=0 next cycle; the following request encodes at BASE_ADDR.
